// File: rtl/alu_md_if.sv
// Execute-stage request/result bundle between the pipeline and alu_md.
interface alu_md_if #(
    parameter int WIDTH = 32
);
    logic             valid_i;
    logic [4:0]       op_i;
    logic             sign_i;
    logic [WIDTH-1:0] din0;
    logic [WIDTH-1:0] din1;
    logic             flush_i;
    logic             ready_o;
    logic             busy_o;
    logic             valid_o;
    logic [WIDTH-1:0] result_o;
    logic             zero_o;
    logic             overflow_o;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;

    modport master (
        output valid_i, op_i, sign_i, din0, din1, flush_i,
        input  ready_o, busy_o, valid_o, result_o, zero_o, overflow_o, hi_o, lo_o
    );

    modport slave (
        input  valid_i, op_i, sign_i, din0, din1, flush_i,
        output ready_o, busy_o, valid_o, result_o, zero_o, overflow_o, hi_o, lo_o
    );
endinterface

// File: rtl/alu_md.sv
// Execute-stage ALU with registered single-cycle ops and an iterative
// shift-add multiplier / restoring divider that owns HI/LO.
module alu_md #(
    parameter int WIDTH = 32
) (
    input logic   clk,
    input logic   rst_n,
    alu_md_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);
    localparam int HW  = WIDTH / 2;
    localparam logic [SHW-1:0] CntLast = SHW'(WIDTH - 1);

    localparam logic [4:0] OpAdd  = 5'd0;
    localparam logic [4:0] OpSub  = 5'd1;
    localparam logic [4:0] OpOr   = 5'd2;
    localparam logic [4:0] OpAnd  = 5'd3;
    localparam logic [4:0] OpXor  = 5'd4;
    localparam logic [4:0] OpNor  = 5'd5;
    localparam logic [4:0] OpLui  = 5'd6;
    localparam logic [4:0] OpSlt  = 5'd7;
    localparam logic [4:0] OpSll  = 5'd8;
    localparam logic [4:0] OpSrl  = 5'd9;
    localparam logic [4:0] OpSra  = 5'd10;
    localparam logic [4:0] OpMult = 5'd11;
    localparam logic [4:0] OpDiv  = 5'd12;
    localparam logic [4:0] OpMthi = 5'd13;
    localparam logic [4:0] OpMtlo = 5'd14;
    localparam logic [4:0] OpMfhi = 5'd15;
    localparam logic [4:0] OpMflo = 5'd16;

    typedef enum logic [1:0] {StIdle, StIter, StFix} state_e;

    state_e             r_state, w_state_d;
    logic [SHW-1:0]     r_cnt, w_cnt_d;
    logic [WIDTH-1:0]   r_result, w_result_d;
    logic               r_valid, w_valid_d;
    logic               r_zero, w_zero_d;
    logic               r_ovf, w_ovf_d;
    logic [WIDTH-1:0]   r_hi, w_hi_d;
    logic [WIDTH-1:0]   r_lo, w_lo_d;
    // MULT: r_acc = product, r_a = shifted multiplicand, r_b = remaining multiplier.
    // DIV:  r_acc = {remainder, dividend/quotient}, r_b = divisor.
    logic [2*WIDTH-1:0] r_acc, w_acc_d;
    logic [2*WIDTH-1:0] r_a, w_a_d;
    logic [WIDTH-1:0]   r_b, w_b_d;
    logic [WIDTH-1:0]   r_op0, w_op0_d;
    logic               r_is_div, w_is_div_d;
    logic               r_neg_q, w_neg_q_d;
    logic               r_neg_r, w_neg_r_d;
    logic               r_dz, w_dz_d;

    logic               w_accept;
    logic               w_is_md;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic               w_lt;
    logic [SHW-1:0]     w_sh;
    logic [WIDTH-1:0]   w_alu_res;
    logic               w_alu_ovf;
    logic               w_alu_zero;
    logic               w_neg0;
    logic               w_neg1;
    logic [WIDTH-1:0]   w_mag0;
    logic [WIDTH-1:0]   w_mag1;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH:0]     w_trial;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;

    assign w_accept = bus.valid_i & (r_state == StIdle) & ~bus.flush_i;
    assign w_is_md  = (bus.op_i == OpMult) || (bus.op_i == OpDiv);
    assign w_sh     = bus.din0[SHW-1:0];

    // Operand magnitudes for the iterative engine; signed fix-up happens in FIX.
    assign w_neg0 = bus.sign_i & bus.din0[WIDTH-1];
    assign w_neg1 = bus.sign_i & bus.din1[WIDTH-1];
    assign w_mag0 = w_neg0 ? (~bus.din0) + 1'b1 : bus.din0;
    assign w_mag1 = w_neg1 ? (~bus.din1) + 1'b1 : bus.din1;

    // One restoring-division step: shift in next dividend bit, try subtract.
    assign w_rem_sh = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_trial  = w_rem_sh - {1'b0, r_b};

    // Sign fix-up of the magnitude results.
    assign w_prod = r_neg_q ? (~r_acc) + 1'b1 : r_acc;
    assign w_quo  = r_neg_q ? (~r_acc[WIDTH-1:0]) + 1'b1 : r_acc[WIDTH-1:0];
    assign w_rem  = r_neg_r ? (~r_acc[2*WIDTH-1:WIDTH]) + 1'b1 : r_acc[2*WIDTH-1:WIDTH];

    // Single-cycle ALU result and flags.
    always_comb begin
        w_sum      = {1'b0, bus.din0} + {1'b0, bus.din1};
        w_diff     = {1'b0, bus.din0} - {1'b0, bus.din1};
        w_lt       = bus.sign_i ? ($signed(bus.din0) < $signed(bus.din1))
                                : (bus.din0 < bus.din1);
        w_alu_res  = '0;
        w_alu_ovf  = 1'b0;
        w_alu_zero = (bus.op_i <= OpMflo) ? (bus.din0 == bus.din1) : 1'b0;
        case (bus.op_i)
            OpAdd: begin
                w_alu_res = w_sum[WIDTH-1:0];
                w_alu_ovf = bus.sign_i ? ((bus.din0[WIDTH-1] == bus.din1[WIDTH-1]) &&
                                          (w_sum[WIDTH-1] != bus.din0[WIDTH-1]))
                                       : w_sum[WIDTH];
            end
            OpSub: begin
                w_alu_res = w_diff[WIDTH-1:0];
                w_alu_ovf = bus.sign_i ? ((bus.din0[WIDTH-1] != bus.din1[WIDTH-1]) &&
                                          (w_diff[WIDTH-1] != bus.din0[WIDTH-1]))
                                       : w_diff[WIDTH];
            end
            OpOr:   w_alu_res = bus.din0 | bus.din1;
            OpAnd:  w_alu_res = bus.din0 & bus.din1;
            OpXor:  w_alu_res = bus.din0 ^ bus.din1;
            OpNor:  w_alu_res = ~(bus.din0 | bus.din1);
            OpLui:  w_alu_res = {bus.din1[HW-1:0], {HW{1'b0}}};
            OpSlt:  w_alu_res = {{(WIDTH-1){1'b0}}, w_lt};
            OpSll:  w_alu_res = bus.din1 << w_sh;
            OpSrl:  w_alu_res = bus.din1 >> w_sh;
            OpSra:  w_alu_res = $unsigned($signed(bus.din1) >>> w_sh);
            OpMthi: w_alu_res = bus.din0;
            OpMtlo: w_alu_res = bus.din0;
            OpMfhi: w_alu_res = r_hi;
            OpMflo: w_alu_res = r_lo;
            default: w_alu_res = '0;
        endcase
    end

    // Control FSM next state plus datapath/output next values.
    always_comb begin
        w_state_d  = r_state;
        w_cnt_d    = r_cnt;
        w_valid_d  = 1'b0;
        w_result_d = r_result;
        w_zero_d   = r_zero;
        w_ovf_d    = r_ovf;
        w_hi_d     = r_hi;
        w_lo_d     = r_lo;
        w_acc_d    = r_acc;
        w_a_d      = r_a;
        w_b_d      = r_b;
        w_op0_d    = r_op0;
        w_is_div_d = r_is_div;
        w_neg_q_d  = r_neg_q;
        w_neg_r_d  = r_neg_r;
        w_dz_d     = r_dz;
        case (r_state)
            StIdle: begin
                if (w_accept) begin
                    if (w_is_md) begin
                        w_state_d  = StIter;
                        w_cnt_d    = '0;
                        w_zero_d   = 1'b0;
                        w_is_div_d = (bus.op_i == OpDiv);
                        w_b_d      = w_mag1;
                        w_op0_d    = bus.din0;
                        w_dz_d     = (bus.din1 == '0);
                        w_neg_q_d  = w_neg0 ^ w_neg1;
                        w_neg_r_d  = w_neg0;
                        if (bus.op_i == OpDiv) begin
                            w_acc_d = {{WIDTH{1'b0}}, w_mag0};
                            w_a_d   = '0;
                        end else begin
                            w_acc_d = '0;
                            w_a_d   = {{WIDTH{1'b0}}, w_mag0};
                        end
                    end else begin
                        w_valid_d  = 1'b1;
                        w_result_d = w_alu_res;
                        w_ovf_d    = w_alu_ovf;
                        w_zero_d   = w_alu_zero;
                        if (bus.op_i == OpMthi) w_hi_d = bus.din0;
                        if (bus.op_i == OpMtlo) w_lo_d = bus.din0;
                    end
                end
            end
            StIter: begin
                if (bus.flush_i) begin
                    w_state_d = StIdle;
                end else begin
                    if (r_is_div) begin
                        if (!w_trial[WIDTH]) begin
                            w_acc_d = {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
                        end else begin
                            w_acc_d = {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        if (r_b[0]) w_acc_d = r_acc + r_a;
                        w_a_d = r_a << 1;
                        w_b_d = r_b >> 1;
                    end
                    w_cnt_d = r_cnt + 1'b1;
                    if (r_cnt == CntLast) w_state_d = StFix;
                end
            end
            StFix: begin
                w_state_d = StIdle;
                if (!bus.flush_i) begin
                    if (!r_is_div) begin
                        w_hi_d = w_prod[2*WIDTH-1:WIDTH];
                        w_lo_d = w_prod[WIDTH-1:0];
                    end else if (r_dz) begin
                        w_hi_d = r_op0;
                        w_lo_d = '1;
                    end else begin
                        w_hi_d = w_rem;
                        w_lo_d = w_quo;
                    end
                    w_result_d = w_lo_d;
                    w_ovf_d    = 1'b0;
                    w_valid_d  = 1'b1;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= StIdle;
            r_cnt    <= '0;
            r_result <= '0;
            r_valid  <= 1'b0;
            r_zero   <= 1'b0;
            r_ovf    <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_acc    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_op0    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dz     <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_cnt    <= w_cnt_d;
            r_result <= w_result_d;
            r_valid  <= w_valid_d;
            r_zero   <= w_zero_d;
            r_ovf    <= w_ovf_d;
            r_hi     <= w_hi_d;
            r_lo     <= w_lo_d;
            r_acc    <= w_acc_d;
            r_a      <= w_a_d;
            r_b      <= w_b_d;
            r_op0    <= w_op0_d;
            r_is_div <= w_is_div_d;
            r_neg_q  <= w_neg_q_d;
            r_neg_r  <= w_neg_r_d;
            r_dz     <= w_dz_d;
        end
    end

    assign bus.ready_o    = (r_state == StIdle);
    assign bus.busy_o     = (r_state == StIter);
    assign bus.valid_o    = r_valid;
    assign bus.result_o   = r_result;
    assign bus.zero_o     = r_zero;
    assign bus.overflow_o = r_ovf;
    assign bus.hi_o       = r_hi;
    assign bus.lo_o       = r_lo;
endmodule

// File: doc/alu_md.md
# alu_md

Parametrised execute-stage arithmetic unit for the pipelined MIPS core: registered single-cycle ALU operations plus an iterative multiply/divide engine owning the HI/LO registers. Sits in EX after the operand forwarding muxes; the pipeline control stalls on `ready_o` and squashes in-flight multiply/divide work with `flush_i` when an interrupt or exception is taken.

## Interface
- `WIDTH`, 32, datapath width; even, ≥ 8.
- `SHW`, $clog2(WIDTH), shift-amount width (derived, not overridden).
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `valid_i`  in  1  operation request.
- `op_i`  in  5  operation code (see Operation).
- `sign_i`  in  1  1 = signed semantics for ADD/SUB/SLT/MULT/DIV.
- `din0`  in  WIDTH  operand A (rs; shift amount for shifts).
- `din1`  in  WIDTH  operand B (rt/immediate; shift source).
- `flush_i`  in  1  abort current/accepting operation.
- `ready_o`  out  1  unit can accept this cycle.
- `busy_o`  out  1  multiply/divide iterating.
- `valid_o`  out  1  `result_o` valid (one-cycle pulse).
- `result_o`  out  WIDTH  registered result.
- `zero_o`  out  1  registered `din0 == din1` (branch compare).
- `overflow_o`  out  1  registered overflow flag.
- `hi_o`, `lo_o`  out  WIDTH  architectural HI/LO.

## Operation
- Accept = `valid_i & ready_o & ~flush_i`. `ready_o` = state IDLE.
- Opcodes: 0 ADD, 1 SUB, 2 OR, 3 AND, 4 XOR, 5 NOR, 6 LUI (`{din1[WIDTH/2-1:0], 0s}`), 7 SLT (signed/unsigned per `sign_i`), 8 SLL, 9 SRL, 10 SRA (`din1` by `din0[SHW-1:0]`), 11 MULT, 12 DIV, 13 MTHI, 14 MTLO, 15 MFHI, 16 MFLO; 17–31 → result 0, no flags.
- Overflow: ADD/SUB with `sign_i`=1: two's-complement overflow; `sign_i`=0: ADD carry-out, SUB borrow (`din0 < din1`). All other ops 0.
- `zero_o` updated on every accepted single-cycle op; 0 for MULT/DIV.
- MTHI/MTLO: HI/LO written at accept edge; `valid_o` pulses, `result_o` = `din0`.
- MULT: shift-add over magnitudes, {HI,LO} = full 2·WIDTH product; signed negates on fix-up if operand signs differ.
- DIV: restoring over magnitudes; LO = quotient (truncated toward zero), HI = remainder (sign of dividend). Divide by zero: LO = all ones, HI = `din0`, no flag.
- MULT/DIV completion: `result_o` = new LO, `overflow_o` = 0.
- State machine: IDLE → (accept MULT/DIV) ITER → (counter = WIDTH-1) FIX → IDLE. Other accepts stay in IDLE.
- `flush_i` in ITER/FIX: back to IDLE next edge, HI/LO unchanged, no `valid_o`. In IDLE: request discarded.

## Timing
- Reset: `result_o`=0, `valid_o`=0, `zero_o`=0, `overflow_o`=0, `hi_o`=`lo_o`=0, `busy_o`=0, `ready_o`=1, counter 0, state IDLE; takes effect immediately, also mid-iteration.
- Single-cycle ops: accept at edge N → `valid_o` high during cycle N+1 only; back-to-back accepts give back-to-back pulses.
- MULT/DIV: accept at edge N; ITER during cycles N+1..N+WIDTH (`busy_o`=1, `ready_o`=0); FIX in cycle N+WIDTH+1 (`ready_o`=0). HI/LO and `result_o` update at the end of FIX; `valid_o` is high in cycle N+WIDTH+2. Next accept possible at that edge.
- MFHI/MFLO after MULT/DIV see new values because `ready_o` stalls until commit.
- `flush_i` deasserts `valid_o` in the following cycle regardless of state.

## Test plan
- WIDTH=32, ADD `sign_i`=1, 0x7FFFFFFF+0x1 → 0x80000000, `overflow_o`=1; `sign_i`=0, 0xFFFFFFFF+0x1 → 0x0, `overflow_o`=1; SUB unsigned 3−5 → 0xFFFFFFFE, `overflow_o`=1.
- SRA `din1`=0x80000000, `din0`=4 → 0xF8000000; `din0`=0 → 0x80000000; SLT signed 0xFFFFFFFF vs 1 → 1, unsigned → 0.
- MULT signed −3×5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1, `valid_o` exactly 34 cycles after the accept edge, `ready_o` low for 33 cycles; MFLO issued during busy completes afterwards with 0xFFFFFFF1.
- DIV signed −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/0 → LO=0xFFFFFFFF, HI=0x7.
- MTHI 0x1234 then MULT aborted by `flush_i` at iteration 10 → no `valid_o`, `hi_o` stays 0x1234, `ready_o` high the next cycle.
- `rst_n` low mid-DIV → all outputs at reset values without waiting for a clock edge; a new ADD accepted after release produces its result one cycle later.
